// File: rtl/mat_elem_stream.sv
// Streaming element-wise matrix sequencer: one LANES-wide A/B read per cycle, in-order result writes.
// Optional MAT_ELEM_PERF_CNT_EN adds perf_cycles_o (saturating accept-to-done cycle count).
module mat_elem_stream #(
    parameter int unsigned LANES   = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned DIM_W   = 10,
    parameter int unsigned LAT_ADD = 7,
    parameter int unsigned LAT_MUL = 5,
    parameter int unsigned LAT_DIV = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    op_valid_i,
    output logic                    op_ready_o,
    input  logic [2:0]              op_code_i,
    input  logic [DIM_W-1:0]        dim_a1_i,
    input  logic [DIM_W-1:0]        dim_a2_i,
    input  logic [DATA_W-1:0]       scalar_i,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    a_read_o,
    output logic [ADDR_W-1:0]       a_addr_o,
    input  logic [LANES*DATA_W-1:0] a_rdata_i,
    output logic                    b_read_o,
    output logic [ADDR_W-1:0]       b_addr_o,
    input  logic [LANES*DATA_W-1:0] b_rdata_i,
    output logic [1:0]              fu_sel_o,
    output logic [LANES*DATA_W-1:0] fu_a_o,
    output logic [LANES*DATA_W-1:0] fu_b_o,
    input  logic [LANES*DATA_W-1:0] fu_res_i,
    output logic                    res_write_o,
    output logic [ADDR_W-1:0]       res_addr_o,
    output logic [LANES*DATA_W-1:0] res_wdata_o
`ifdef MAT_ELEM_PERF_CNT_EN
    ,
    output logic [31:0]             perf_cycles_o
`endif
);
    localparam int unsigned W      = LANES * DATA_W;
    localparam int unsigned LatAm  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int unsigned LatMax = (LatAm > LAT_DIV) ? LatAm : LAT_DIV;
    localparam int unsigned TW     = (LatMax > 1) ? $clog2(LatMax) : 1;
    localparam int unsigned PW     = 2 * DIM_W + 1;
    localparam int unsigned NW     = ADDR_W + 1;

    localparam logic [2:0] OpAdd     = 3'd0;
    localparam logic [2:0] OpScalMul = 3'd1;
    localparam logic [2:0] OpScalDiv = 3'd2;
    localparam logic [2:0] OpScalAdd = 3'd3;
    localparam logic [2:0] OpScalInv = 3'd4;
    localparam logic [2:0] OpEleMul  = 3'd5;
    localparam logic [DATA_W-1:0] FpOne = DATA_W'(32'h3F800000);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    function automatic logic [1:0] unit_of(input logic [2:0] op);
        case (op)
            OpAdd, OpScalAdd:    unit_of = 2'd0;
            OpEleMul, OpScalMul: unit_of = 2'd1;
            default:             unit_of = 2'd2;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   scalar_q, scalar_d;
    logic [NW-1:0]       n_q, n_d, cnt_q, cnt_d;
    logic [1:0]          fu_sel_q, fu_sel_d;
    logic                done_q, done_d, err_q, err_d;
    logic                rd_vld_q, rd_vld_d, op_vld_q, op_vld_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, op_addr_q, op_addr_d;
    logic [W-1:0]        fu_a_q, fu_a_d, fu_b_q, fu_b_d;
    logic [LatMax-1:0]   dl_vld_q, dl_vld_d;
    logic [ADDR_W-1:0]   dl_addr_q [LatMax];
    logic [ADDR_W-1:0]   dl_addr_d [LatMax];

    logic [2*DIM_W-1:0]  prod;
    logic [PW-1:0]       words;
    logic [NW-1:0]       n_words;
    logic                legal, issue, last_word, pending;
    int unsigned         lat_sel;
    logic [TW-1:0]       tap;

    // Word count rounds up to whole LANES-wide words and saturates at the address space size.
    assign prod    = {{DIM_W{1'b0}}, dim_a1_i} * {{DIM_W{1'b0}}, dim_a2_i};
    assign words   = ({1'b0, prod} + PW'(LANES - 1)) / PW'(LANES);
    assign n_words = (words > PW'(2 ** ADDR_W)) ? NW'(2 ** ADDR_W) : words[NW-1:0];

    assign legal     = (op_code_i <= OpEleMul);
    assign issue     = (state_q == StIssue);
    assign last_word = (cnt_q == n_q - NW'(1));

    always_comb begin
        lat_sel = LAT_DIV;
        case (fu_sel_q)
            2'd0:    lat_sel = LAT_ADD;
            2'd1:    lat_sel = LAT_MUL;
            default: lat_sel = LAT_DIV;
        endcase
        tap = TW'(lat_sel - 1);
    end

    // Anything still in flight ahead of the write stage keeps DRAIN alive.
    always_comb begin
        pending = rd_vld_q | op_vld_q;
        for (int unsigned k = 0; k < LatMax; k++) begin
            if (k + 1 < lat_sel) pending = pending | dl_vld_q[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        scalar_d = scalar_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        fu_sel_d = fu_sel_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (op_valid_i) begin
                    if (!legal) begin
                        err_d = 1'b1;
                    end else begin
                        op_d     = op_code_i;
                        scalar_d = scalar_i;
                        n_d      = n_words;
                        cnt_d    = '0;
                        fu_sel_d = unit_of(op_code_i);
                        if (n_words == '0) done_d = 1'b1;
                        else state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d = cnt_q + NW'(1);
                if (last_word) state_d = StDrain;
            end
            StDrain: begin
                if (!pending) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_vld_d  = issue;
        rd_addr_d = cnt_q[ADDR_W-1:0];
        op_vld_d  = rd_vld_q;
        op_addr_d = rd_addr_q;
        fu_a_d    = '0;
        fu_b_d    = '0;
        if (rd_vld_q) begin
            fu_a_d = a_rdata_i;
            case (op_q)
                OpAdd, OpEleMul:        fu_b_d = b_rdata_i;
                OpScalInv: begin
                    fu_a_d = {LANES{FpOne}};
                    fu_b_d = a_rdata_i;
                end
                default:                fu_b_d = {LANES{scalar_q}};
            endcase
        end
        dl_vld_d[0]  = op_vld_q;
        dl_addr_d[0] = op_addr_q;
        for (int unsigned k = 1; k < LatMax; k++) begin
            dl_vld_d[k]  = dl_vld_q[k-1];
            dl_addr_d[k] = dl_addr_q[k-1];
        end
        // Stages past a shorter unit's tap can hold stale tags; flush them between ops.
        if (state_q == StIdle) dl_vld_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            op_q      <= '0;
            scalar_q  <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            fu_sel_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            op_vld_q  <= 1'b0;
            op_addr_q <= '0;
            fu_a_q    <= '0;
            fu_b_q    <= '0;
            dl_vld_q  <= '0;
            dl_addr_q <= '{default: '0};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            scalar_q  <= scalar_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            fu_sel_q  <= fu_sel_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
            op_vld_q  <= op_vld_d;
            op_addr_q <= op_addr_d;
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
            dl_vld_q  <= dl_vld_d;
            dl_addr_q <= dl_addr_d;
        end
    end

    assign op_ready_o  = (state_q == StIdle);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign a_read_o    = issue;
    assign a_addr_o    = issue ? cnt_q[ADDR_W-1:0] : '0;
    assign b_read_o    = issue && ((op_q == OpAdd) || (op_q == OpEleMul));
    assign b_addr_o    = b_read_o ? cnt_q[ADDR_W-1:0] : '0;
    assign fu_sel_o    = fu_sel_q;
    assign fu_a_o      = fu_a_q;
    assign fu_b_o      = fu_b_q;
    assign res_write_o = dl_vld_q[tap];
    assign res_addr_o  = res_write_o ? dl_addr_q[tap] : '0;
    assign res_wdata_o = res_write_o ? fu_res_i : '0;

`ifdef MAT_ELEM_PERF_CNT_EN
    logic [31:0] pc_cnt_q, pc_cnt_d, pc_lat_q, pc_lat_d, pc_inc;

    assign pc_inc = (pc_cnt_q == '1) ? pc_cnt_q : pc_cnt_q + 32'd1;

    always_comb begin
        pc_cnt_d = pc_cnt_q;
        pc_lat_d = pc_lat_q;
        if (state_q == StIdle) begin
            if (op_valid_i && legal) begin
                pc_cnt_d = 32'd1;
                if (n_words == '0) pc_lat_d = 32'd1;
            end
        end else begin
            pc_cnt_d = pc_inc;
            if (state_d == StIdle) pc_lat_d = pc_inc;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_cnt_q <= '0;
            pc_lat_q <= '0;
        end else begin
            pc_cnt_q <= pc_cnt_d;
            pc_lat_q <= pc_lat_d;
        end
    end

    assign perf_cycles_o = pc_lat_q;
`endif
endmodule

// File: tb/tb_mat_elem_stream.sv
// Scoreboard bench for mat_elem_stream; FP lanes are modelled by integer stand-in functions.
module tb_mat_elem_stream;
    localparam int LANES = 8, DATA_W = 32, ADDR_W = 11, DIM_W = 10;
    localparam int LAT_ADD = 7, LAT_MUL = 5, LAT_DIV = 6;
    localparam int W = LANES * DATA_W;
    localparam logic [31:0] ONE = 32'h3F800000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic op_valid = 1'b0, op_ready, done, err;
    logic [2:0] op_code = '0;
    logic [DIM_W-1:0] dim_a1 = '0, dim_a2 = '0;
    logic [DATA_W-1:0] scalar = '0;
    logic a_read, b_read, res_write;
    logic [ADDR_W-1:0] a_addr, b_addr, res_addr;
    logic [W-1:0] a_rdata = '0, b_rdata = '0, fu_a, fu_b, fu_res, res_wdata;
    logic [1:0] fu_sel;
`ifdef MAT_ELEM_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    always #5 clk = ~clk;

    mat_elem_stream #(
        .LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W),
        .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)
    ) dut (
`ifdef MAT_ELEM_PERF_CNT_EN
        .perf_cycles_o(perf_cycles),
`endif
        .clk_i(clk), .rst_i(rst), .op_valid_i(op_valid), .op_ready_o(op_ready),
        .op_code_i(op_code), .dim_a1_i(dim_a1), .dim_a2_i(dim_a2), .scalar_i(scalar),
        .done_o(done), .err_o(err), .a_read_o(a_read), .a_addr_o(a_addr), .a_rdata_i(a_rdata),
        .b_read_o(b_read), .b_addr_o(b_addr), .b_rdata_i(b_rdata), .fu_sel_o(fu_sel),
        .fu_a_o(fu_a), .fu_b_o(fu_b), .fu_res_i(fu_res), .res_write_o(res_write),
        .res_addr_o(res_addr), .res_wdata_o(res_wdata)
    );

    logic [W-1:0] mem_a [256];
    logic [W-1:0] mem_b [256];
    logic [W-1:0] hist_a [8];
    logic [W-1:0] hist_b [8];
    int cyc = 0;
    int checks = 0, failures = 0;
    int n_a = 0, n_b = 0, n_w = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [W-1:0]      data;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [31:0] fu_lane(input logic [1:0] sel, input logic [31:0] a, b);
        case (sel)
            2'd0:    fu_lane = a + b;
            2'd1:    fu_lane = a * b;
            default: fu_lane = (a << 1) ^ b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd3) lat_of = LAT_ADD;
        else if (op == 3'd1 || op == 3'd5) lat_of = LAT_MUL;
        else lat_of = LAT_DIV;
    endfunction

    // Expected result word, straight from the per-op operand rules.
    function automatic logic [W-1:0] exp_word(input logic [2:0] op, input int i,
                                              input logic [31:0] s);
        logic [31:0] a, b, r;
        exp_word = '0;
        for (int l = 0; l < LANES; l++) begin
            a = mem_a[i][l*32 +: 32];
            b = mem_b[i][l*32 +: 32];
            case (op)
                3'd0:    r = fu_lane(2'd0, a, b);
                3'd3:    r = fu_lane(2'd0, a, s);
                3'd5:    r = fu_lane(2'd1, a, b);
                3'd1:    r = fu_lane(2'd1, a, s);
                3'd2:    r = fu_lane(2'd2, a, s);
                default: r = fu_lane(2'd2, ONE, a);
            endcase
            exp_word[l*32 +: 32] = r;
        end
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        a_rdata <= a_read ? mem_a[a_addr[7:0]] : {LANES{$urandom}};
        b_rdata <= b_read ? mem_b[b_addr[7:0]] : {LANES{$urandom}};
        hist_a[0] <= fu_a;
        hist_b[0] <= fu_b;
        for (int k = 1; k < 8; k++) begin
            hist_a[k] <= hist_a[k-1];
            hist_b[k] <= hist_b[k-1];
        end
    end

    always_comb begin : fu_model
        int j;
        j = ((fu_sel == 2'd0) ? LAT_ADD : (fu_sel == 2'd1) ? LAT_MUL : LAT_DIV) - 1;
        fu_res = '0;
        for (int l = 0; l < LANES; l++)
            fu_res[l*32 +: 32] = fu_lane(fu_sel, hist_a[j][l*32 +: 32], hist_b[j][l*32 +: 32]);
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_read) n_a++;
            if (b_read) n_b++;
            if (res_write) begin
                n_w++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write got_addr=%0h exp=no_write", res_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("res_addr", W'(res_addr), W'(e.addr));
                    check("res_wdata", res_wdata, e.data);
                end
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input int d1, input int d2,
                          input logic [31:0] s);
        int n, c0, exp_lat;
        bit seen;
        exp_t e;
        n = (d1 * d2 + LANES - 1) / LANES;
        if (n > 2048) n = 2048;
        @(negedge clk);
        check("op_ready_idle", W'(op_ready), W'(1));
        n_a = 0; n_b = 0; n_w = 0;
        if (op <= 3'd5) begin
            for (int i = 0; i < n; i++) begin
                e.addr = i[ADDR_W-1:0];
                e.data = exp_word(op, i, s);
                exp_q.push_back(e);
            end
        end
        op_valid = 1'b1;
        op_code  = op;
        dim_a1   = d1[DIM_W-1:0];
        dim_a2   = d2[DIM_W-1:0];
        scalar   = s;
        c0       = cyc;
        @(posedge clk);
        #1 op_valid = 1'b0;
        if (op > 3'd5) begin
            @(negedge clk);
            check("err_pulse", W'(err), W'(1));
            check("op_ready_err", W'(op_ready), W'(1));
            check("done_on_err", W'(done), W'(0));
            @(negedge clk);
            check("err_one_cycle", W'(err), W'(0));
            check("reads_on_err", W'(n_a + n_b), W'(0));
            return;
        end
        exp_lat = (n == 0) ? 1 : n + lat_of(op) + 3;
        seen = 1'b0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=no_done exp_latency=%0d", exp_lat);
            exp_q.delete();
            return;
        end
        check("done_latency", W'(cyc - c0), W'(exp_lat));
        check("op_ready_at_done", W'(op_ready), W'(1));
        check("write_count", W'(n_w), W'(n));
        check("a_reads", W'(n_a), W'(n));
        check("b_reads", W'(n_b), W'((op == 3'd0 || op == 3'd5) ? n : 0));
        check("queue_drained", W'(exp_q.size()), W'(0));
`ifdef MAT_ELEM_PERF_CNT_EN
        check("perf_cycles", W'(perf_cycles), W'(exp_lat));
`endif
        @(negedge clk);
        check("done_one_cycle", W'(done), W'(0));
    endtask

    task automatic reset_mid_op();
        exp_t e;
        bit hit;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            e.addr = i[ADDR_W-1:0];
            e.data = exp_word(3'd5, i, 32'h0);
            exp_q.push_back(e);
        end
        op_valid = 1'b1; op_code = 3'd5; dim_a1 = 10'd8; dim_a2 = 10'd64;
        @(posedge clk);
        #1 op_valid = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            if (a_read && a_addr == 11'd10) hit = 1'b1;
        end
        check("reached_word10", W'(hit), W'(1));
        rst = 1'b1;
        #1;
        check("rst_a_read", W'(a_read), W'(0));
        check("rst_b_read", W'(b_read), W'(0));
        check("rst_res_write", W'(res_write), W'(0));
        check("rst_op_ready", W'(op_ready), W'(1));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        n_w = 0;
        repeat (20) @(negedge clk);
        check("no_write_after_reset", W'(n_w), W'(0));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            for (int l = 0; l < LANES; l++) begin
                mem_a[i][l*32 +: 32] = $urandom;
                mem_b[i][l*32 +: 32] = $urandom;
            end
        end
        repeat (3) @(negedge clk);
        check("reset_op_ready", W'(op_ready), W'(1));
        check("reset_strobes", W'({a_read, b_read, res_write, done, err}), W'(0));
        check("reset_addrs", W'({a_addr, b_addr, res_addr}), W'(0));
        check("reset_data", res_wdata | fu_a | fu_b, W'(0));
        check("reset_fu_sel", W'(fu_sel), W'(0));
`ifdef MAT_ELEM_PERF_CNT_EN
        check("reset_perf", W'(perf_cycles), W'(0));
`endif
        rst = 1'b0;

        mem_a[0] = {LANES{32'h3F800000}}; mem_a[1] = {LANES{32'h3F800000}};
        mem_b[0] = {LANES{32'h40000000}}; mem_b[1] = {LANES{32'h40000000}};
        run_op(3'd0, 4, 4, 32'h0);
        mem_a[0] = {LANES{32'h40800000}};
        run_op(3'd4, 1, 8, 32'h0);
        run_op(3'd5, 32, 32, 32'h0);
        run_op(3'd6, 4, 4, 32'h0);
        run_op(3'd7, 2, 3, 32'h0);
        run_op(3'd3, 0, 5, 32'h1234);
        run_op(3'd1, 8, 16, 32'h0000_0003);
        reset_mid_op();
        run_op(3'd2, 3, 5, 32'h55AA_0F0F);
        for (int t = 0; t < 12; t++) begin
            run_op(3'($urandom_range(0, 5)), int'($urandom_range(0, 12)),
                   int'($urandom_range(0, 12)), $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
